// File: rtl/nes_controller_responder_pkg.sv
// Shared NES controller definitions: button indices and the serial shift order,
// so host and responder agree on which pad button travels in which bit slot.
package nes_controller_responder_pkg;

    typedef enum logic [2:0] {
        NES_BUTTON_RIGHT  = 3'd0,
        NES_BUTTON_LEFT   = 3'd1,
        NES_BUTTON_DOWN   = 3'd2,
        NES_BUTTON_UP     = 3'd3,
        NES_BUTTON_START  = 3'd4,
        NES_BUTTON_SELECT = 3'd5,
        NES_BUTTON_B      = 3'd6,
        NES_BUTTON_A      = 3'd7
    } nes_button_e;

    localparam int NES_FRAME_BITS = 8;

    // Element i is the button that appears on the data line after i clock rises.
    localparam nes_button_e NES_SERIAL_ORDER [NES_FRAME_BITS] = '{
        NES_BUTTON_A, NES_BUTTON_B, NES_BUTTON_SELECT, NES_BUTTON_START,
        NES_BUTTON_UP, NES_BUTTON_DOWN, NES_BUTTON_LEFT, NES_BUTTON_RIGHT
    };

    function automatic logic [7:0] nes_serial_image(input logic [7:0] buttons);
        logic [7:0] img;
        img = 8'hFF;
        for (int i = 0; i < NES_FRAME_BITS; i++) begin
            img[i] = ~buttons[NES_SERIAL_ORDER[i]];
        end
        return img;
    endfunction

endpackage

// File: rtl/nes_pin_filter.sv
// Conditions one asynchronous host pin: 2-flop synchronizer, stable-count level
// filter, and registered rise/fall strobes on the filtered level.
module nes_pin_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] FILTER_LAST = 4'(FILTER_CYCLES - 1);

    logic       meta_q, meta_d;
    logic       sync_q, sync_d;
    logic       level_q, level_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // Filter state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Level flips only once the synchronized pin has disagreed for FILTER_CYCLES samples
    always_comb begin
        meta_d  = i_pin;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = 4'd0;
        if (sync_q != level_q) begin
            if (cnt_q == FILTER_LAST) begin
                level_d = sync_q;
                cnt_d   = 4'd0;
            end else begin
                level_d = level_q;
                cnt_d   = cnt_q + 4'd1;
            end
        end else begin
            level_d = level_q;
            cnt_d   = 4'd0;
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/nes_controller_responder.sv
// Device side of the NES pad protocol: parallel-loads the button snapshot while
// the host latch is high, then shifts it out active-low on each host clock rise.
module nes_controller_responder
    import nes_controller_responder_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_buttons,
    input  logic       i_controller_latch,
    input  logic       i_controller_clock,
    output logic       o_controller_data,
    output logic       o_latched,
    output logic       o_frame_done,
    output logic [3:0] o_bit_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic       latch_level, latch_rise, latch_fall;
    logic       clk_level, clk_rise, clk_fall;
    logic       unused_s;

    logic [1:0] state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] count_q, count_d;
    logic       latched_q, latched_d;
    logic       done_q, done_d;

    nes_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_latch_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_controller_latch),
        .o_level (latch_level),
        .o_rise  (latch_rise),
        .o_fall  (latch_fall)
    );

    nes_pin_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clock_filter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_pin   (i_controller_clock),
        .o_level (clk_level),
        .o_rise  (clk_rise),
        .o_fall  (clk_fall)
    );

    assign unused_s = ^{latch_level, clk_level, clk_fall};

    // State, shift register and registered strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            sr_q      <= 8'hFF;
            count_q   <= 4'd0;
            latched_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            count_q   <= count_d;
            latched_q <= latched_d;
            done_q    <= done_d;
        end
    end

    // Next state: a latch rise always wins, so a mid-frame latch aborts the frame
    always_comb begin
        state_d = state_q;
        if (latch_rise) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_fall) state_d = ST_SHIFT;
                    else            state_d = ST_LOAD;
                end
                ST_SHIFT: begin
                    if (clk_rise && (count_q == 4'd7)) state_d = ST_DONE;
                    else                               state_d = ST_SHIFT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and strobes; the load is skipped on the fall cycle so the frame keeps
    // the snapshot taken while the latch was still high
    always_comb begin
        sr_d      = sr_q;
        count_d   = count_q;
        latched_d = 1'b0;
        done_d    = 1'b0;
        if (latch_rise) begin
            sr_d    = nes_serial_image(i_buttons);
            count_d = 4'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (latch_fall) begin
                        latched_d = 1'b1;
                        count_d   = 4'd0;
                    end else begin
                        sr_d    = nes_serial_image(i_buttons);
                        count_d = 4'd0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_d    = {1'b1, sr_q[7:1]};
                        count_d = count_q + 4'd1;
                        if (count_q == 4'd7) done_d = 1'b1;
                        else                 done_d = 1'b0;
                    end else begin
                        sr_d    = sr_q;
                        count_d = count_q;
                    end
                end
                default: begin
                    sr_d    = sr_q;
                    count_d = count_q;
                end
            endcase
        end
    end

    assign o_controller_data = sr_q[0];
    assign o_latched         = latched_q;
    assign o_frame_done      = done_q;
    assign o_bit_count       = count_q;

endmodule
